// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - multiply/divide issue control: start pulse, HI/LO writes, busy tracking, decode stall
module md_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr_D,
  input  logic [31:0] Instr_E,
  input  logic        IRQ_E,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        hi_we,
  output logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic        stall_D
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_busy;

  logic w_e_rtype;
  logic w_e_start;
  logic w_e_mthi;
  logic w_e_mtlo;
  logic w_d_md;
  logic w_idle;
  logic w_issue_ok;
  logic w_unused_bits;

  assign w_e_rtype = (Instr_E[31:26] == 6'b000000);
  assign w_e_start = w_e_rtype && (Instr_E[5:2] == 4'b0110);
  assign w_e_mthi  = w_e_rtype && (Instr_E[5:0] == 6'b010001);
  assign w_e_mtlo  = w_e_rtype && (Instr_E[5:0] == 6'b010011);

  // Start-class funct 0110xx plus HI/LO moves 0100xx cover all eight MD functs.
  assign w_d_md = (Instr_D[31:26] == 6'b000000) &&
                  ((Instr_D[5:2] == 4'b0110) || (Instr_D[5:2] == 4'b0100));

  assign w_idle     = (r_state == IDLE);
  assign w_issue_ok = !reset && w_idle && !IRQ_E;

  assign md_start = w_issue_ok && w_e_start;
  assign md_op    = Instr_E[1:0];
  assign hi_we    = w_issue_ok && w_e_mthi;
  assign lo_we    = w_issue_ok && w_e_mtlo;
  assign busy     = r_busy;
  assign done     = !reset && r_busy && (r_cnt == 4'd1);
  assign stall_D  = !reset && w_d_md && (r_busy || md_start);

  assign w_unused_bits = ^{Instr_D[25:6], Instr_E[25:6]};

  // Once started the operation is committed; IRQ_E and new starts are ignored while BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (md_start) begin
            r_state <= BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= Instr_E[1] ? 4'd10 : 4'd5;
          end
        end
        BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - scoreboard bench for md_issue_ctrl with directed per-cycle vectors
module tb_md_issue_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0000_0018;
  localparam logic [31:0] MULTU = 32'h0000_0019;
  localparam logic [31:0] DIV   = 32'h0000_001A;
  localparam logic [31:0] DIVU  = 32'h0000_001B;
  localparam logic [31:0] MFHI  = 32'h0000_0010;
  localparam logic [31:0] MTHI  = 32'h0000_0011;
  localparam logic [31:0] MFLO  = 32'h0000_0012;
  localparam logic [31:0] MTLO  = 32'h0000_0013;
  localparam logic [31:0] ADD   = 32'h0000_0020;
  localparam logic [31:0] LWX   = 32'h8C00_0018;

  logic        clk;
  logic        reset;
  logic [31:0] Instr_D;
  logic [31:0] Instr_E;
  logic        IRQ_E;
  logic        md_start;
  logic [1:0]  md_op;
  logic        hi_we;
  logic        lo_we;
  logic        busy;
  logic        done;
  logic        stall_D;

  int tests_run = 0;
  int tests_failed = 0;

  // {md_start, md_op[1:0], hi_we, lo_we, busy, done, stall_D}
  logic [7:0] exp_q[$];
  string      name_q[$];

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .Instr_D(Instr_D), .Instr_E(Instr_E), .IRQ_E(IRQ_E),
    .md_start(md_start), .md_op(md_op), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .stall_D(stall_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic vec(input string nm, input logic [31:0] d, input logic [31:0] e,
                     input logic irq, input logic rst, input logic st, input logic [1:0] op,
                     input logic hw, input logic lw, input logic bsy, input logic dn,
                     input logic stl);
    @(posedge clk);
    #1;
    Instr_D = d;
    Instr_E = e;
    IRQ_E   = irq;
    reset   = rst;
    exp_q.push_back({st, op, hw, lw, bsy, dn, stl});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {md_start, md_op, hi_we, lo_we, busy, done, stall_D};
      if (!e[7]) begin
        e[6:5] = 2'b00;
        a[6:5] = 2'b00;
      end
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s: got start/op/hw/lw/busy/done/stall=%b required %b", nm, a, e);
      end
    end
  end

  initial begin
    reset = 1'b1; Instr_D = NOP; Instr_E = NOP; IRQ_E = 1'b0;
    @(posedge clk);

    vec("reset_gate", MFLO, MULT, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("reset_gate_hi", MFHI, MTHI, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("idle_after_reset", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("mult_start", NOP, MULT, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) vec("mult_busy", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("mult_done", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0);
    vec("mult_idle", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("divu_start_stall", MFLO, DIVU, 0, 0, 1, 2'd3, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 9; i++) vec("divu_busy_stall", MFLO, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1);
    vec("divu_done_stall", MFLO, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 1);
    vec("divu_mflo_proceeds", MFLO, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("div_irq_suppress", MFHI, DIV, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("div_irq_stays_idle", MFHI, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("mthi_idle", NOP, MTHI, 0, 0, 0, 2'd0, 1, 0, 0, 0, 0);
    vec("mtlo_idle", NOP, MTLO, 0, 0, 0, 2'd0, 0, 1, 0, 0, 0);
    vec("mthi_irq", NOP, MTHI, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("mtlo_irq", NOP, MTLO, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("multu_start", NOP, MULTU, 0, 0, 1, 2'd1, 0, 0, 0, 0, 0);
    vec("mthi_in_busy", NOP, MTHI, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("div_in_busy_ignored", NOP, DIV, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("busy_nonmd_d", ADD, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("busy_mtlo_d", MTLO, MTLO, 0, 0, 0, 2'd0, 0, 0, 1, 0, 1);
    vec("multu_done_no_reload", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0);
    vec("multu_idle", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("mult_irq_start", NOP, MULT, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    vec("mult_irq_c1", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("mult_irq_c2", NOP, NOP, 1, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("mult_irq_c3", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("mult_irq_c4", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("mult_irq_done", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0);
    vec("mult_irq_idle", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("div_abort_start", NOP, DIV, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    vec("div_abort_c1", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("div_abort_c2", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("div_abort_c3_reset", MFHI, NOP, 0, 1, 0, 2'd0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) vec("div_abort_no_done", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("fresh_multu_start", MFHI, MULTU, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) vec("fresh_multu_busy", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("fresh_multu_done", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 1, 0);

    vec("abort_at_cnt1_start", NOP, MULT, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) vec("abort_at_cnt1_busy", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("abort_at_cnt1_reset", NOP, NOP, 0, 1, 0, 2'd0, 0, 0, 1, 0, 0);
    vec("abort_at_cnt1_idle", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    vec("nonmd_add", ADD, ADD, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("nonmd_opcode", LWX, LWX, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    vec("nonmd_after", NOP, NOP, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d vectors unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
